spi_adxl_master: RTL and testbench

//  SPI transaction engine answering the accelerometer register sequencer's req/ack interface.

---
 rtl/spi_adxl_master.sv | 195 +++++++++++++++++++
 tb/tb_spi_adxl_master.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_adxl_master.sv
// spi_adxl_master
// Runs one 16-bit SPI mode-3 frame (CPOL=1, CPHA=1) to the ADXL345 for each request
// from the register sequencer. It returns the byte clocked in during bits 7..0 with a
// one-cycle ack.
//
// Ports
//   clk_i       system clock
//   rst_i       asynchronous active-high reset
//   req_i       transaction request (level), sampled only while idle
//   pachet_i    command: [15]=R/W (1=read) [14]=MB [13:8]=reg addr [7:0]=write data
//   ack_o       one-cycle pulse when the frame is finished and data_o is valid
//   data_o      last read byte; held across write frames
//   busy_o      high from request acceptance until the chip-select gap has elapsed
//   spi_cs_n_o  chip select, active low
//   spi_sclk_o  SPI clock, idles high
//   spi_mosi_o  master data out, MSB first
//   spi_miso_i  slave data in
module spi_adxl_master #(
    parameter int unsigned CLK_DIV = 25,  // clk_i cycles per SCLK half-period, >= 2
    parameter int unsigned CS_GAP  = 4    // clk_i cycles with CS_N high after ack, >= 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic [15:0] pachet_i,
    output logic        ack_o,
    output logic [7:0]  data_o,
    output logic        busy_o,
    output logic        spi_cs_n_o,
    output logic        spi_sclk_o,
    output logic        spi_mosi_o,
    input  logic        spi_miso_i
);

    localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned GapW = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
    localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);
    localparam logic [GapW-1:0] GapLast = GapW'(CS_GAP - 1);

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StShift,
        StHold,
        StAck,
        StGap
    } state_e;

    state_e          state_q, state_d;
    logic [DivW-1:0] div_q, div_d;
    logic [GapW-1:0] gap_q, gap_d;
    logic [4:0]      bit_cnt_q, bit_cnt_d;  // rising SCLK edges completed in this frame
    logic [15:0]     tx_q, tx_d;
    logic [7:0]      rx_q, rx_d;
    logic            ack_q, ack_d;
    logic [7:0]      data_q, data_d;
    logic            busy_q, busy_d;
    logic            cs_n_q, cs_n_d;
    logic            sclk_q, sclk_d;
    logic            mosi_q, mosi_d;

    logic            div_last;
    logic [3:0]      tx_idx;

    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        gap_d     = gap_q;
        bit_cnt_d = bit_cnt_q;
        tx_d      = tx_q;
        rx_d      = rx_q;
        ack_d     = 1'b0;
        data_d    = data_q;
        busy_d    = busy_q;
        cs_n_d    = cs_n_q;
        sclk_d    = sclk_q;
        mosi_d    = mosi_q;
        div_last  = (div_q == DivLast);
        // On falling edge k (k >= 2) bit_cnt_q == k-1, so the bit to present is 16-k.
        tx_idx    = 4'd15 - bit_cnt_q[3:0];

        unique case (state_q)
            StIdle: begin
                if (req_i) begin
                    tx_d      = pachet_i;
                    cs_n_d    = 1'b0;
                    mosi_d    = pachet_i[15];
                    busy_d    = 1'b1;
                    div_d     = '0;
                    bit_cnt_d = '0;
                    state_d   = StSetup;
                end
            end

            StSetup: begin
                if (div_last) begin
                    // First falling edge; MOSI already carries bit 15 from acceptance.
                    div_d   = '0;
                    sclk_d  = 1'b0;
                    state_d = StShift;
                end else begin
                    div_d = div_q + DivW'(1);
                end
            end

            StShift: begin
                if (div_last) begin
                    div_d = '0;
                    if (!sclk_q) begin
                        sclk_d    = 1'b1;
                        rx_d      = {rx_q[6:0], spi_miso_i};
                        bit_cnt_d = bit_cnt_q + 5'd1;
                        if (bit_cnt_q == 5'd15) begin
                            state_d = StHold;
                        end
                    end else begin
                        sclk_d = 1'b0;
                        mosi_d = tx_q[tx_idx];
                    end
                end else begin
                    div_d = div_q + DivW'(1);
                end
            end

            StHold: begin
                if (div_last) begin
                    div_d   = '0;
                    cs_n_d  = 1'b1;
                    mosi_d  = 1'b1;
                    ack_d   = 1'b1;
                    gap_d   = '0;
                    state_d = StAck;
                    if (tx_q[15]) begin
                        data_d = rx_q;
                    end
                end else begin
                    div_d = div_q + DivW'(1);
                end
            end

            // The ack cycle is the first cycle of the chip-select gap.
            StAck, StGap: begin
                if (gap_q == GapLast) begin
                    busy_d  = 1'b0;
                    state_d = StIdle;
                end else begin
                    gap_d   = gap_q + GapW'(1);
                    state_d = StGap;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= StIdle;
            div_q     <= '0;
            gap_q     <= '0;
            bit_cnt_q <= '0;
            tx_q      <= '0;
            rx_q      <= '0;
            ack_q     <= 1'b0;
            data_q    <= '0;
            busy_q    <= 1'b0;
            cs_n_q    <= 1'b1;
            sclk_q    <= 1'b1;
            mosi_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            gap_q     <= gap_d;
            bit_cnt_q <= bit_cnt_d;
            tx_q      <= tx_d;
            rx_q      <= rx_d;
            ack_q     <= ack_d;
            data_q    <= data_d;
            busy_q    <= busy_d;
            cs_n_q    <= cs_n_d;
            sclk_q    <= sclk_d;
            mosi_q    <= mosi_d;
        end
    end

    assign ack_o      = ack_q;
    assign data_o     = data_q;
    assign busy_o     = busy_q;
    assign spi_cs_n_o = cs_n_q;
    assign spi_sclk_o = sclk_q;
    assign spi_mosi_o = mosi_q;

endmodule

// File: tb/tb_spi_adxl_master.sv
// tb_spi_adxl_master
// Drives two instances: default timing (CLK_DIV=25, CS_GAP=4) and fast timing
// (CLK_DIV=2, CS_GAP=1). A sequencer-style driver launches frames. For each frame it
// queues the expected packet, ack cycle and data byte. These follow from the frame
// timing rules: ack 33 half-periods after acceptance, earliest restart ack+CS_GAP+1,
// and a read returns the slave byte while a write keeps the old one. A per-cycle process
// plays the ADXL slave and records the MOSI word. It also compares every ack against
// the oldest pending expectation.
module tb_spi_adxl_master;

    localparam int unsigned Div0 = 25;
    localparam int unsigned Gap0 = 4;
    localparam int unsigned Div1 = 2;
    localparam int unsigned Gap1 = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        req   [2];
    logic [15:0] pkt   [2];
    logic        miso  [2] = '{1'b1, 1'b1};
    logic        ack   [2];
    logic [7:0]  data  [2];
    logic        busy  [2];
    logic        cs_n  [2];
    logic        sclk  [2];
    logic        mosi  [2];

    always #5 clk = ~clk;

    spi_adxl_master #(.CLK_DIV(Div0), .CS_GAP(Gap0)) u_dut0 (
        .clk_i(clk), .rst_i(rst), .req_i(req[0]), .pachet_i(pkt[0]), .ack_o(ack[0]),
        .data_o(data[0]), .busy_o(busy[0]), .spi_cs_n_o(cs_n[0]), .spi_sclk_o(sclk[0]),
        .spi_mosi_o(mosi[0]), .spi_miso_i(miso[0])
    );

    spi_adxl_master #(.CLK_DIV(Div1), .CS_GAP(Gap1)) u_dut1 (
        .clk_i(clk), .rst_i(rst), .req_i(req[1]), .pachet_i(pkt[1]), .ack_o(ack[1]),
        .data_o(data[1]), .busy_o(busy[1]), .spi_cs_n_o(cs_n[1]), .spi_sclk_o(sclk[1]),
        .spi_mosi_o(mosi[1]), .spi_miso_i(miso[1])
    );

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Expectation store: written by the driver, consumed in order by the checker.
    int          e_dut   [64];
    logic [15:0] e_pkt   [64];
    int unsigned e_cyc   [64];
    logic [7:0]  e_data  [64];
    bit          e_abort [64];
    int          wr = 0;

    logic [7:0]  sbyte     [2];
    logic [7:0]  exp_last  [2];
    int unsigned next_free [2];
    bit          done = 1'b0;

    function automatic int unsigned div_of(input int g);
        return (g == 0) ? Div0 : Div1;
    endfunction

    function automatic int unsigned gap_of(input int g);
        return (g == 0) ? Gap0 : Gap1;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cyc(input int unsigned c);
        while (cyc < c) step();
    endtask

    // mode 0: hold req until the cycle after ack, then drop it
    // mode 1: leave req high and return in the ack cycle (back-to-back frames)
    // mode 2: return right after raising req; the caller manages req afterwards
    task automatic issue(input int g, input logic [15:0] p, input logic [7:0] b,
                         input int mode, output int unsigned ack_c);
        int unsigned e0;
        while (cyc + 1 < next_free[g]) step();
        pkt[g]   = p;
        sbyte[g] = b;
        req[g]   = 1'b1;
        e0       = cyc + 1;
        ack_c    = e0 + 33 * div_of(g);
        e_dut[wr]   = g;
        e_pkt[wr]   = p;
        e_cyc[wr]   = ack_c;
        e_data[wr]  = p[15] ? b : exp_last[g];
        e_abort[wr] = 1'b0;
        exp_last[g] = e_data[wr];
        wr++;
        next_free[g] = ack_c + gap_of(g) + 1;
        if (mode == 0) begin
            wait_cyc(ack_c + 1);
            req[g] = 1'b0;
        end else if (mode == 1) begin
            wait_cyc(ack_c);
        end
    endtask

    // Slave model and checker, evaluated on the falling clk edge.
    int          n_checks = 0;
    int          n_fail   = 0;
    int          rd       = 0;
    int          falls   [2] = '{0, 0};
    int          rises   [2] = '{0, 0};
    logic [15:0] cap     [2] = '{16'h0, 16'h0};
    logic        prev_cs [2] = '{1'b1, 1'b1};
    logic        prev_sk [2] = '{1'b1, 1'b1};

    task automatic chk(input string name, input int g, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d cycle %0d: got 0x%0h expected 0x%0h",
                     name, g, cyc, got, exp);
        end
    endtask

    always @(negedge clk) begin
        for (int g = 0; g < 2; g++) begin
            if (rst) begin
                chk("rst_cs_n", g, 32'(cs_n[g]), 32'd1);
                chk("rst_sclk", g, 32'(sclk[g]), 32'd1);
                chk("rst_mosi", g, 32'(mosi[g]), 32'd1);
                chk("rst_busy", g, 32'(busy[g]), 32'd0);
                chk("rst_ack", g, 32'(ack[g]), 32'd0);
                chk("rst_data", g, 32'(data[g]), 32'd0);
            end
            if (prev_cs[g] === 1'b1 && cs_n[g] === 1'b0) begin
                falls[g] = 0;
                rises[g] = 0;
                cap[g]   = 16'h0;
            end
            if (cs_n[g] === 1'b0 && sclk[g] !== prev_sk[g]) begin
                if (sclk[g] === 1'b0) begin
                    falls[g]++;
                    if (falls[g] >= 9 && falls[g] <= 16) begin
                        miso[g] = sbyte[g][3'(16 - falls[g])];
                    end else begin
                        miso[g] = 1'($urandom_range(0, 1));
                    end
                end else begin
                    rises[g]++;
                    cap[g] = {cap[g][14:0], mosi[g]};
                end
            end
            prev_cs[g] = cs_n[g];
            prev_sk[g] = sclk[g];

            if (ack[g] === 1'b1) begin
                while (rd < wr && e_abort[rd]) rd++;
                if (rd >= wr || e_dut[rd] != g) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_ack dut%0d cycle %0d: got ack expected none",
                             g, cyc);
                end else begin
                    chk("ack_cycle", g, 32'(cyc), 32'(e_cyc[rd]));
                    chk("data_o", g, 32'(data[g]), 32'(e_data[rd]));
                    chk("mosi_word", g, 32'(cap[g]), 32'(e_pkt[rd]));
                    chk("sclk_falls", g, 32'(falls[g]), 32'd16);
                    chk("sclk_rises", g, 32'(rises[g]), 32'd16);
                    chk("cs_n_at_ack", g, 32'(cs_n[g]), 32'd1);
                    chk("busy_at_ack", g, 32'(busy[g]), 32'd1);
                    rd++;
                end
            end
        end

        if (done) begin
            while (rd < wr && e_abort[rd]) rd++;
            chk("frames_acked", 0, 32'(rd), 32'(wr));
            $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
            $finish;
        end
    end

    initial begin
        int unsigned a;
        int unsigned e0;
        rst       = 1'b1;
        req       = '{1'b0, 1'b0};
        pkt       = '{16'h0, 16'h0};
        sbyte     = '{8'h0, 8'h0};
        exp_last  = '{8'h0, 8'h0};
        next_free = '{0, 0};
        repeat (3) step();
        rst = 1'b0;

        // Read DATAX1 returning 0xA5, then a DATAFORMAT write that must keep 0xA5.
        issue(0, 16'hB300, 8'hA5, 0, a);
        issue(0, 16'h310C, 8'h5A, 0, a);

        // Sequencer init then alternating X/Y reads.
        issue(0, 16'h310C, 8'($urandom), 0, a);
        issue(0, 16'h2C0B, 8'($urandom), 0, a);
        issue(0, 16'h2D08, 8'($urandom), 0, a);
        for (int i = 0; i < 2; i++) begin
            issue(0, 16'hB300, 8'h12, 0, a);
            issue(0, 16'hB500, 8'h34, 0, a);
        end

        // Reset during bit 9 of a read: frame is dropped, data cleared.
        issue(0, 16'hB200, 8'hC3, 2, a);
        e0 = a - 33 * Div0;
        wait_cyc(e0 + 17 * Div0 + 3);
        #1;
        rst              = 1'b1;
        req[0]           = 1'b0;
        e_abort[wr - 1]  = 1'b1;
        exp_last         = '{8'h0, 8'h0};
        repeat (2) step();
        rst          = 1'b0;
        next_free[0] = cyc + 1;
        next_free[1] = cyc + 1;
        issue(0, 16'hB300, 8'h81, 0, a);

        // req toggling and pachet_i changes while a frame is in flight.
        issue(0, 16'hB400, 8'h6E, 2, a);
        e0 = a - 33 * Div0;
        wait_cyc(e0 + 100);
        req[0] = 1'b0;
        pkt[0] = 16'h0000;
        wait_cyc(cyc + 20);
        req[0] = 1'b1;
        pkt[0] = 16'($urandom);
        wait_cyc(cyc + 10);
        req[0] = 1'b0;
        pkt[0] = 16'hFFFF;
        wait_cyc(a + 1);

        repeat (4) begin
            repeat ($urandom_range(0, 7)) step();
            issue(0, 16'($urandom), 8'($urandom), 0, a);
        end

        // Fast instance: one isolated frame, then req held high for back-to-back frames.
        issue(1, 16'h310C, 8'h00, 0, a);
        for (int i = 0; i < 10; i++) begin
            issue(1, 16'($urandom), 8'($urandom), 1, a);
        end
        wait_cyc(a + 1);
        req[1] = 1'b0;
        repeat (3) begin
            repeat ($urandom_range(0, 5)) step();
            issue(1, 16'($urandom) | 16'h8000, 8'($urandom), 0, a);
        end

        repeat (100) step();
        done = 1'b1;
    end

endmodule
